bus_xfer_ctrl: RTL and testbench
================================

BUS_XFER_CTRL -- requirements
Module: bus_xfer_ctrl

Interface
REQ-001: Parameters SHALL be: FIFO_DEPTH, default 4, command queue entries (power of two); CNT_W, default 8, transfer counter width.
REQ-002: The clock is `clk`, a single clock; all state SHALL change on its rising edge only.
REQ-003: The reset is `rst_n`, synchronous and active-low, sampled on the rising edge of `clk`.
REQ-004: `clk`  in  1  system clock.
REQ-005: `rst_n`  in  1  synchronous active-low reset.
REQ-006: `cmd_valid`  in  1  a transfer command is offered.
REQ-007: `cmd_src`  in  2  source endpoint: 0..2 = bus registers R1..R3; 3 = external port.
REQ-008: `cmd_dst`  in  2  destination endpoint, same encoding as `cmd_src`.
REQ-009: `cmd_ready`  out  1  queue can accept a command.
REQ-010: `sel`  out  3  register selects; bit i selects register R(i+1).
REQ-011: `rnw`  out  3  per-register direction; 1 = capture from bus, 0 = drive the bus while selected.
REQ-012: `ext_in_en`  out  1  external port drives the shared bus.
REQ-013: `ext_out_en`  out  1  shared bus drives the external port.
REQ-014: `busy`  out  1  FSM is not in IDLE.
REQ-015: `done`  out  1  one-cycle pulse when a transfer completes.
REQ-016: `err`  out  1  one-cycle pulse when a command is rejected.
REQ-017: `xfer_count`  out  CNT_W  count of completed transfers.

Function
REQ-018: A command SHALL be pushed when `cmd_valid` and `cmd_ready` are both high; `cmd_ready` SHALL equal NOT full.
REQ-019: When the queue is full, `cmd_valid` SHALL be ignored and the queue SHALL be left unchanged.
REQ-020: The FSM SHALL have the states IDLE, SETUP, WRITE, DONE and ERR.
REQ-021: In IDLE with the queue not empty, the FSM SHALL pop the head into the current-command register on that edge.
REQ-022: After such a pop, the next state SHALL be ERR if src == dst, otherwise SETUP.
REQ-023: SETUP SHALL last one cycle with the source driving and no destination active, then go to WRITE.
REQ-024: WRITE SHALL last one cycle with the source driving and the destination capturing, then go to DONE.
REQ-025: DONE SHALL last one cycle, pulse `done`, increment `xfer_count` (wrapping at 2^CNT_W), then go to IDLE.
REQ-026: ERR SHALL last one cycle, pulse `err`, leave all selects and enables low and `xfer_count` unchanged, then go to IDLE.
REQ-027: Source driving SHALL be: register i drives with sel[i]=1, rnw[i]=0; external source drives with ext_in_en=1.
REQ-028: Destination capture SHALL be: register j captures with sel[j]=1, rnw[j]=1; external destination with ext_out_en=1.
REQ-029: Outputs SHALL be decoded only from registered state and the current-command register, with no combinational path from the cmd_* inputs.
REQ-030: At most one bus driver SHALL be active in any cycle (one of: a register with rnw=0, or ext_in_en).
REQ-031: ext_in_en and ext_out_en SHALL never be high together.
REQ-032: Outside SETUP and WRITE, sel, rnw, ext_in_en and ext_out_en SHALL all be 0.
REQ-033: Latency from pop to `done` SHALL be 3 cycles; throughput SHALL be one transfer per 4 cycles.
REQ-034: A push and a pop in the same cycle SHALL both take effect and leave the occupancy unchanged.
REQ-035: A pop is only possible from a non-empty queue.
REQ-036: `busy` SHALL be high in SETUP, WRITE, DONE and ERR.

Reset
REQ-037: On a rising edge of `clk` with `rst_n` low, the FSM SHALL go to IDLE.
REQ-038: On that edge, the queue SHALL be emptied, giving `cmd_ready`=1.
REQ-039: On that edge, sel, rnw, ext_in_en, ext_out_en, busy, done, err and xfer_count SHALL all be 0.
REQ-040: A reset during SETUP or WRITE SHALL abort the transfer: no `done`, no count increment, and all drivers low in the following cycle.

Structure
REQ-041: A shared package SHALL hold the state enum, the endpoint encoding constants (EP_R1=0, EP_R2=1, EP_R3=2, EP_EXT=3) and the command struct {src, dst}.
REQ-042: The command queue SHALL be a separate sub-module, `cmd_fifo`, a synchronous FIFO with full/empty flags.
REQ-043: The FSM and output decode SHALL reside in `bus_xfer_ctrl`.

Verification
REQ-044: Single transfer: push src=0, dst=2 →
- SETUP: sel=001, rnw=000.
- WRITE: sel=101, rnw=100.
- DONE: `done`=1; xfer_count=1; R3 holds the R1 value.
REQ-045: External in/out: push (3,1) then (1,3) →
- First command: ext_in_en high in SETUP and WRITE; R2 captures the external byte.
- Second command: ext_out_en high only in WRITE.
- The enables never overlap.
REQ-046: Illegal command: push (2,2) → `err` pulses once, no select asserted, xfer_count unchanged.
REQ-047: Full queue: push 5 commands back-to-back at the FSM's start →
- `cmd_ready` low after the 4th command is stored (one is already in flight).
- The 5th command is accepted once a pop occurs.
- Exactly 5 `done` pulses follow.
REQ-048: Reset in WRITE of (0,1) →
- Next cycle: all outputs 0 and `cmd_ready`=1.
- No `done` pulse.
- Queued commands are discarded.
REQ-049: Counter wrap: with CNT_W=8, 256 legal transfers → xfer_count returns to 0.
REQ-050: Every scenario SHALL check the single-driver condition of REQ-030 on every cycle.

Source files
------------

// File: rtl/bus_xfer_ctrl_pkg.sv
// Shared types for the bus transfer controller: FSM states, endpoint codes,
// the queued command record and the bus-control decode helper.
package bus_xfer_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  typedef logic [1:0] ep_t;

  localparam ep_t EP_R1  = 2'd0;
  localparam ep_t EP_R2  = 2'd1;
  localparam ep_t EP_R3  = 2'd2;
  localparam ep_t EP_EXT = 2'd3;

  typedef struct packed {
    ep_t src;
    ep_t dst;
  } cmd_t;

  typedef struct packed {
    logic [2:0] sel;
    logic [2:0] rnw;
    logic       ext_in_en;
    logic       ext_out_en;
  } bus_ctl_t;

  // Source always drives; the destination is only enabled in the capture phase.
  function automatic bus_ctl_t decode_ctl(input cmd_t cmd, input logic capture);
    bus_ctl_t ctl;
    ctl = '0;
    case (cmd.src)
      EP_R1:   ctl.sel[0] = 1'b1;
      EP_R2:   ctl.sel[1] = 1'b1;
      EP_R3:   ctl.sel[2] = 1'b1;
      default: ctl.ext_in_en = 1'b1;
    endcase
    if (capture) begin
      case (cmd.dst)
        EP_R1: begin
          ctl.sel[0] = 1'b1;
          ctl.rnw[0] = 1'b1;
        end
        EP_R2: begin
          ctl.sel[1] = 1'b1;
          ctl.rnw[1] = 1'b1;
        end
        EP_R3: begin
          ctl.sel[2] = 1'b1;
          ctl.rnw[2] = 1'b1;
        end
        default: ctl.ext_out_en = 1'b1;
      endcase
    end
    return ctl;
  endfunction

endpackage

// File: rtl/bus_xfer_ctrl_chk.sv
// Property checker for the transfer controller's bus-safety outputs.
module bus_xfer_ctrl_chk (
  input logic       clk,
  input logic       rst_n,
  input logic [2:0] sel,
  input logic [2:0] rnw,
  input logic       ext_in_en,
  input logic       ext_out_en,
  input logic       busy,
  input logic       done,
  input logic       err
);

  a_single_driver: assert property (@(posedge clk) disable iff (!rst_n)
    $countones({sel & ~rnw, ext_in_en}) <= 1);

  a_ext_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(ext_in_en && ext_out_en));

  a_idle_quiet: assert property (@(posedge clk) disable iff (!rst_n)
    !busy |-> (sel == 3'b000 && rnw == 3'b000 && !ext_in_en && !ext_out_en));

  a_done_err_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(done && err));

endmodule

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with full/empty flags; push is ignored when full
// and pop is ignored when empty.
module cmd_fifo
  import bus_xfer_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  cmd_t push_cmd,
  input  logic pop,
  output cmd_t head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  cmd_t        mem_r [DEPTH];
  logic        push_ok_s;
  logic        pop_ok_s;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign head      = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update; simultaneous push and pop both advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= push_cmd;
    end
  end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Queued register-to-register bus transfer controller: pops commands from
// cmd_fifo and sequences SETUP/WRITE/DONE with fully registered outputs.
module bus_xfer_ctrl
  import bus_xfer_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_src,
  input  logic [1:0]       cmd_dst,
  output logic             cmd_ready,
  output logic [2:0]       sel,
  output logic [2:0]       rnw,
  output logic             ext_in_en,
  output logic             ext_out_en,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] xfer_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t   state_r;
  cmd_t     cur_cmd_r;
  bus_ctl_t ctl_r;
  cmd_t     push_cmd_s;
  cmd_t     head_s;
  logic     fifo_full_s;
  logic     fifo_empty_s;
  logic     pop_s;

  assign push_cmd_s.src = cmd_src;
  assign push_cmd_s.dst = cmd_dst;
  assign cmd_ready      = !fifo_full_s;
  assign pop_s          = (state_r == ST_IDLE) && !fifo_empty_s;

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (cmd_valid),
    .push_cmd (push_cmd_s),
    .pop      (pop_s),
    .head     (head_s),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s)
  );

  // Sequencer; bus controls are computed for the state being entered so they
  // come straight from flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      cur_cmd_r  <= '0;
      ctl_r      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      xfer_count <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (!fifo_empty_s) begin
            cur_cmd_r <= head_s;
            busy      <= 1'b1;
            if (head_s.src == head_s.dst) begin
              state_r <= ST_ERR;
              ctl_r   <= '0;
              err     <= 1'b1;
            end else begin
              state_r <= ST_SETUP;
              ctl_r   <= decode_ctl(head_s, 1'b0);
            end
          end else begin
            state_r <= ST_IDLE;
            ctl_r   <= '0;
            busy    <= 1'b0;
          end
        end
        ST_SETUP: begin
          state_r <= ST_WRITE;
          ctl_r   <= decode_ctl(cur_cmd_r, 1'b1);
          busy    <= 1'b1;
        end
        ST_WRITE: begin
          state_r    <= ST_DONE;
          ctl_r      <= '0;
          busy       <= 1'b1;
          done       <= 1'b1;
          xfer_count <= xfer_count + CNT_ONE;
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          ctl_r   <= '0;
          busy    <= 1'b0;
        end
        ST_ERR: begin
          state_r <= ST_IDLE;
          ctl_r   <= '0;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          ctl_r   <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  assign sel        = ctl_r.sel;
  assign rnw        = ctl_r.rnw;
  assign ext_in_en  = ctl_r.ext_in_en;
  assign ext_out_en = ctl_r.ext_out_en;

  bus_xfer_ctrl_chk u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .sel        (sel),
    .rnw        (rnw),
    .ext_in_en  (ext_in_en),
    .ext_out_en (ext_out_en),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Self-checking bench for bus_xfer_ctrl: transaction-level reference model
// plus a small model of the three registers and external port on the bus.
module tb_bus_xfer_ctrl;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic [1:0]       cmd_src;
  logic [1:0]       cmd_dst;
  logic             cmd_ready;
  logic [2:0]       sel;
  logic [2:0]       rnw;
  logic             ext_in_en;
  logic             ext_out_en;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] xfer_count;

  bus_xfer_ctrl #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_src(cmd_src),
    .cmd_dst(cmd_dst), .cmd_ready(cmd_ready), .sel(sel), .rnw(rnw),
    .ext_in_en(ext_in_en), .ext_out_en(ext_out_en), .busy(busy),
    .done(done), .err(err), .xfer_count(xfer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0] sel;
    logic [2:0] rnw;
    logic       ein;
    logic       eout;
    logic       busy;
    logic       done;
    logic       err;
  } exp_t;

  typedef struct {
    logic [1:0] src;
    logic [1:0] dst;
  } mcmd_t;

  // Reference model: pending commands and the per-cycle output schedule of
  // the transfer in progress.
  mcmd_t            mq[$];
  exp_t             pend[$];
  exp_t             cur = '0;
  logic [CNT_W-1:0] mcount = '0;
  int               done_seen = 0;

  logic [7:0] r [3];
  logic [7:0] ext_byte;
  logic [7:0] ext_sink;
  logic [7:0] bus;

  function automatic exp_t xfer_vec(input logic [1:0] s, input logic [1:0] d,
                                    input bit capture);
    exp_t e;
    e = '0;
    e.busy = 1'b1;
    if (s == 2'd3) e.ein = 1'b1;
    else e.sel = 3'b001 << s;
    if (capture) begin
      if (d == 2'd3) e.eout = 1'b1;
      else begin
        e.sel = e.sel | (3'b001 << d);
        e.rnw = 3'b001 << d;
      end
    end
    return e;
  endfunction

  always @(posedge clk) begin
    mcmd_t c;
    exp_t  e;
    bit    can_push;
    if (!rst_n) begin
      mq.delete();
      pend.delete();
      cur = '0;
      mcount = '0;
    end else begin
      can_push = (mq.size() < DEPTH);
      if (pend.size() != 0) begin
        cur = pend.pop_front();
      end else if (mq.size() != 0) begin
        c = mq.pop_front();
        if (c.src == c.dst) begin
          e = '0;
          e.busy = 1'b1;
          e.err = 1'b1;
          cur = e;
          pend.push_back(exp_t'(0));
        end else begin
          cur = xfer_vec(c.src, c.dst, 1'b0);
          pend.push_back(xfer_vec(c.src, c.dst, 1'b1));
          e = '0;
          e.busy = 1'b1;
          e.done = 1'b1;
          pend.push_back(e);
          pend.push_back(exp_t'(0));
        end
      end else begin
        cur = '0;
      end
      if (cur.done) mcount = mcount + 8'd1;
      if (cmd_valid && can_push) begin
        c.src = cmd_src;
        c.dst = cmd_dst;
        mq.push_back(c);
      end
    end
  end

  // Per-cycle comparison against the model, plus the bus/register environment.
  always @(negedge clk) begin
    exp_t act;
    act = {sel, rnw, ext_in_en, ext_out_en, busy, done, err};
    checks++;
    if (act !== cur) begin
      errors++;
      $display("FAIL outputs: got sel=%b rnw=%b ein=%b eout=%b busy=%b done=%b err=%b, expected sel=%b rnw=%b ein=%b eout=%b busy=%b done=%b err=%b",
               act.sel, act.rnw, act.ein, act.eout, act.busy, act.done, act.err,
               cur.sel, cur.rnw, cur.ein, cur.eout, cur.busy, cur.done, cur.err);
    end
    checks++;
    if (xfer_count !== mcount) begin
      errors++;
      $display("FAIL xfer_count: got %0d expected %0d", xfer_count, mcount);
    end
    checks++;
    if (cmd_ready !== (mq.size() < DEPTH)) begin
      errors++;
      $display("FAIL cmd_ready: got %b expected %b", cmd_ready, (mq.size() < DEPTH));
    end
    checks++;
    if ($countones({sel & ~rnw, ext_in_en}) > 1 || (ext_in_en === 1'b1 && ext_out_en === 1'b1)) begin
      errors++;
      $display("FAIL single_driver: sel=%b rnw=%b ein=%b eout=%b, expected at most one driver",
               sel, rnw, ext_in_en, ext_out_en);
    end
    if (done === 1'b1) done_seen++;
    bus = 8'h00;
    if (ext_in_en === 1'b1) bus = ext_byte;
    for (int j = 0; j < 3; j++) if (sel[j] === 1'b1 && rnw[j] === 1'b0) bus = r[j];
    for (int j = 0; j < 3; j++) if (sel[j] === 1'b1 && rnw[j] === 1'b1) r[j] = bus;
    if (ext_out_en === 1'b1) ext_sink = bus;
  end

  task automatic drive(input logic v, input logic [1:0] s, input logic [1:0] d);
    @(negedge clk);
    cmd_valid = v;
    cmd_src   = s;
    cmd_dst   = d;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((mq.size() != 0 || pend.size() != 0) && k < 80) begin
      drive(1'b0, 2'd0, 2'd0);
      k++;
    end
    drive(1'b0, 2'd0, 2'd0);
    checks++;
    if (k >= 80) begin
      errors++;
      $display("FAIL idle_timeout: controller still active after %0d cycles, expected idle", k);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({sel, rnw, ext_in_en, ext_out_en, busy, done, err, xfer_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got sel=%b rnw=%b ein=%b eout=%b busy=%b done=%b err=%b cnt=%0d, expected all 0",
               sel, rnw, ext_in_en, ext_out_en, busy, done, err, xfer_count);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 1", cmd_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int k;
    logic [CNT_W-1:0] c0;
    wait_idle();
    c0 = mcount;
    r[0] = 8'h3C; r[1] = 8'h5A; r[2] = 8'h00;
    drive(1'b1, 2'd0, 2'd2);
    drive(1'b0, 2'd0, 2'd0);
    k = 0;
    while (busy !== 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (sel !== 3'b001 || rnw !== 3'b000) begin
      errors++;
      $display("FAIL single_setup: got sel=%b rnw=%b expected 001/000", sel, rnw);
    end
    @(negedge clk);
    checks++;
    if (sel !== 3'b101 || rnw !== 3'b100) begin
      errors++;
      $display("FAIL single_write: got sel=%b rnw=%b expected 101/100", sel, rnw);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || xfer_count !== c0 + 8'd1) begin
      errors++;
      $display("FAIL single_done: got done=%b cnt=%0d expected 1/%0d", done, xfer_count, c0 + 8'd1);
    end
    @(negedge clk);
    checks++;
    if (r[2] !== 8'h3C) begin
      errors++;
      $display("FAIL single_data: R3=%h expected 3c", r[2]);
    end
  endtask

  task automatic test_ext();
    int in_cnt, out_cnt, overlap;
    wait_idle();
    ext_byte = 8'($urandom);
    r[1] = ~ext_byte;
    ext_sink = 8'h00;
    drive(1'b1, 2'd3, 2'd1);
    drive(1'b1, 2'd1, 2'd3);
    drive(1'b0, 2'd0, 2'd0);
    in_cnt = 0; out_cnt = 0; overlap = 0;
    for (int i = 0; i < 16; i++) begin
      if (ext_in_en === 1'b1) in_cnt++;
      if (ext_out_en === 1'b1) out_cnt++;
      if (ext_in_en === 1'b1 && ext_out_en === 1'b1) overlap++;
      @(negedge clk);
    end
    checks++;
    if (in_cnt != 2 || out_cnt != 1 || overlap != 0) begin
      errors++;
      $display("FAIL ext_enables: in=%0d out=%0d overlap=%0d expected 2/1/0", in_cnt, out_cnt, overlap);
    end
    checks++;
    if (r[1] !== ext_byte || ext_sink !== ext_byte) begin
      errors++;
      $display("FAIL ext_data: R2=%h port=%h expected %h", r[1], ext_sink, ext_byte);
    end
  endtask

  task automatic test_illegal();
    int errs, dones, active;
    logic [CNT_W-1:0] c0;
    wait_idle();
    c0 = mcount;
    drive(1'b1, 2'd2, 2'd2);
    drive(1'b0, 2'd0, 2'd0);
    errs = 0; dones = 0; active = 0;
    for (int i = 0; i < 8; i++) begin
      if (err === 1'b1) errs++;
      if (done === 1'b1) dones++;
      if (sel !== 3'b000 || ext_in_en !== 1'b0 || ext_out_en !== 1'b0) active++;
      @(negedge clk);
    end
    checks++;
    if (errs != 1 || dones != 0 || active != 0 || xfer_count !== c0) begin
      errors++;
      $display("FAIL illegal: err=%0d done=%0d active=%0d cnt=%0d expected 1/0/0/%0d",
               errs, dones, active, xfer_count, c0);
    end
  endtask

  task automatic test_full();
    int d0;
    logic [1:0] s;
    wait_idle();
    d0 = done_seen;
    for (int i = 0; i < 5; i++) begin
      s = 2'($urandom_range(0, 3));
      drive(1'b1, s, s + 2'($urandom_range(1, 3)));
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready: got %b expected 0", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_src = 2'd0; cmd_dst = 2'd1;
    drive(1'b0, 2'd0, 2'd0);
    repeat (30) @(negedge clk);
    checks++;
    if (done_seen - d0 != 5) begin
      errors++;
      $display("FAIL full_dones: got %0d expected 5", done_seen - d0);
    end
  endtask

  task automatic test_reset_in_write();
    int k, d0;
    wait_idle();
    d0 = done_seen;
    drive(1'b1, 2'd0, 2'd1);
    drive(1'b1, 2'd2, 2'd3);
    drive(1'b1, 2'd3, 2'd0);
    drive(1'b0, 2'd0, 2'd0);
    k = 0;
    while (!(sel === 3'b011 && rnw === 3'b010) && k < 12) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= 12) begin
      errors++;
      $display("FAIL rst_write_wait: WRITE of (0,1) not seen in %0d cycles", k);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({sel, rnw, ext_in_en, ext_out_en, busy, done, err, xfer_count} !== '0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_write_outputs: sel=%b rnw=%b ein=%b eout=%b busy=%b done=%b cnt=%0d ready=%b expected all 0, ready 1",
               sel, rnw, ext_in_en, ext_out_en, busy, done, xfer_count, cmd_ready);
    end
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if (done_seen != d0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_write_discard: dones=%0d busy=%b expected 0/0", done_seen - d0, busy);
    end
  endtask

  task automatic test_wrap();
    int accepted, k, d0;
    logic [1:0] s;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    d0 = done_seen;
    accepted = 0;
    k = 0;
    while ((accepted < 256 || mq.size() != 0 || pend.size() != 0) && k < 3000) begin
      @(negedge clk);
      if (accepted < 256 && cmd_ready === 1'b1) begin
        s = 2'($urandom_range(0, 3));
        cmd_valid = 1'b1; cmd_src = s; cmd_dst = s + 2'($urandom_range(1, 3));
        accepted++;
      end else begin
        cmd_valid = 1'b0;
      end
      k++;
    end
    drive(1'b0, 2'd0, 2'd0);
    checks++;
    if (done_seen - d0 != 256 || xfer_count !== 8'd0) begin
      errors++;
      $display("FAIL wrap: dones=%0d cnt=%0d expected 256/0", done_seen - d0, xfer_count);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rst_n     = ($urandom_range(0, 99) != 0);
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_src   = 2'($urandom_range(0, 3));
      cmd_dst   = 2'($urandom_range(0, 3));
    end
    @(negedge clk);
    rst_n = 1'b1;
    cmd_valid = 1'b0;
    wait_idle();
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_src = 2'd0;
    cmd_dst = 2'd0;
    r[0] = 8'h00; r[1] = 8'h00; r[2] = 8'h00;
    ext_byte = 8'hA5;
    ext_sink = 8'h00;
    test_reset();
    test_single();
    test_ext();
    test_illegal();
    test_full();
    test_reset_in_write();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
